// File: rtl/reqack_fanout_buffer_pkg.sv
// Shared definitions for the req/ack fan-out buffer: handshake state
// encoding and the pointer-width helper used by the top and the storage array.
package reqack_fanout_buffer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   // Pointer width for a power-of-2 depth; pointers wrap naturally at depth.
   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/reqack_fifo_mem.sv
// Storage array for the fan-out buffer: depth x data_width registers,
// synchronous write, asynchronous read at the read pointer.
module reqack_fifo_mem
   import reqack_fanout_buffer_pkg::*;
#(
   parameter int data_width = 32,
   parameter int depth      = 4
) (
   input  logic                         clk,
   input  logic                         wr_en,
   input  logic [ptr_width(depth)-1:0]  wr_ptr,
   input  logic [data_width-1:0]        wr_data,
   input  logic [ptr_width(depth)-1:0]  rd_ptr,
   output logic [data_width-1:0]        rd_data
);

   logic [data_width-1:0] mem [depth];

   // Store the pushed word at the write pointer.
   // NOTE: the array has no reset; occupancy is tracked by level, so stale
   // contents are never observable and resetting them would only cost flops.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/reqack_fanout_buffer.sv
// Buffered responder for the dataflow req/ack channel: words pushed on a
// valid/ready port are queued and each is served to all requesters at once
// through a single shared, one-cycle ack pulse.
module reqack_fanout_buffer
   import reqack_fanout_buffer_pkg::*;
#(
   parameter int data_width  = 32,
   parameter int depth       = 4,
   parameter int output_size = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [data_width-1:0]   in_data,
   input  logic [output_size-1:0]  req_r,
   output logic                    ack_r,
   output logic [data_width-1:0]   dout,
   output logic [$clog2(depth):0]  level,
   output logic [31:0]             served
);

   localparam int ptr_w = ptr_width(depth);
   localparam logic [ptr_w:0] full_level = depth[ptr_w:0];

   state_t               state;
   logic [ptr_w-1:0]     wr_ptr;
   logic [ptr_w-1:0]     rd_ptr;
   logic [data_width-1:0] head;
   logic                 wr_en;
   logic                 serve;

   // Full is judged from registered level only, so a same-cycle serve
   // never frees a slot for the write in that cycle.
   assign in_ready = (level != full_level);
   assign wr_en    = in_valid & in_ready;

   reqack_fifo_mem #(
      .data_width (data_width),
      .depth      (depth)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_ptr  (wr_ptr),
      .wr_data (in_data),
      .rd_ptr  (rd_ptr),
      .rd_data (head)
   );

   // Serve only when idle, no ack outstanding, a word is stored and every
   // requester is asking.
   // NOTE: assigning a default first keeps every path driven, so no latch.
   always_comb begin
      serve = 1'b0;
      if (state == IDLE && !ack_r && level != '0 && (&req_r)) begin
         serve = 1'b1;
      end
   end

   // Handshake FSM: IDLE issues the ack pulse with the head word, WAIT
   // drops it while the requesters lower their requests.
   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ack_r  <= 1'b0;
         dout   <= '0;
         rd_ptr <= '0;
         served <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (serve) begin
                  dout   <= head;
                  rd_ptr <= rd_ptr + 1'b1;
                  ack_r  <= 1'b1;
                  state  <= WAIT;
                  served <= served + 32'd1;
               end
            end
            WAIT: begin
               ack_r <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Write pointer and occupancy: level is writes minus serves.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         case ({wr_en, serve})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule
